// File: rtl/adt7420_poll_ctrl.sv
// ============================================================================
// Module   : adt7420_poll_ctrl
// Brief    : ADT7420 sequencer that configures the sensor once, then polls
//            its 16-bit temperature register through a byte-level I2C engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adt7420_poll_ctrl #(
    parameter logic [6:0] DEV_ADDR    = 7'h4B,
    parameter logic [7:0] CFG_VALUE   = 8'h80,
    parameter int         POLL_CYCLES = 100_000_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic        system_clk,
    input  logic        Rst,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic [15:0] temperature,
    output logic        temp_valid,
    output logic        busy,
    output logic        fault,
    output logic [7:0]  err_cnt
);

    localparam logic [2:0]  c_CMD_START = 3'd0;
    localparam logic [2:0]  c_CMD_WRITE = 3'd1;
    localparam logic [2:0]  c_CMD_RACK  = 3'd2;
    localparam logic [2:0]  c_CMD_RNACK = 3'd3;
    localparam logic [2:0]  c_CMD_STOP  = 3'd4;
    localparam logic [26:0] c_POLL_LOAD = 27'(POLL_CYCLES - 1);

    // LAUNCH keeps cmd_valid low for the cycle in which reset is released
    typedef enum logic [2:0] {
        ST_LAUNCH = 3'd0,
        ST_OFFER  = 3'd1,
        ST_RESP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_read;
    logic [2:0]  r_step;
    logic        r_abort;
    logic [1:0]  r_retry;
    logic [26:0] r_poll;
    logic [7:0]  r_msb;
    logic [7:0]  r_lsb;
    logic [15:0] r_temp;
    logic        r_temp_valid;
    logic [7:0]  r_err_cnt;

    logic [2:0]  w_seq_cmd;
    logic [7:0]  w_seq_data;
    logic        w_rsp;
    logic        w_retry_done;

    // Command table indexed by step; an aborted sequence only ever emits STOP
    always_comb begin
        w_seq_cmd  = c_CMD_STOP;
        w_seq_data = 8'h00;
        if (r_is_read) begin
            case (r_step)
                3'd0:    w_seq_cmd = c_CMD_START;
                3'd1:    begin w_seq_cmd = c_CMD_WRITE; w_seq_data = {DEV_ADDR, 1'b0}; end
                3'd2:    begin w_seq_cmd = c_CMD_WRITE; w_seq_data = 8'h00;            end
                3'd3:    w_seq_cmd = c_CMD_START;
                3'd4:    begin w_seq_cmd = c_CMD_WRITE; w_seq_data = {DEV_ADDR, 1'b1}; end
                3'd5:    w_seq_cmd = c_CMD_RACK;
                3'd6:    w_seq_cmd = c_CMD_RNACK;
                default: w_seq_cmd = c_CMD_STOP;
            endcase
        end else begin
            case (r_step)
                3'd0:    w_seq_cmd = c_CMD_START;
                3'd1:    begin w_seq_cmd = c_CMD_WRITE; w_seq_data = {DEV_ADDR, 1'b0}; end
                3'd2:    begin w_seq_cmd = c_CMD_WRITE; w_seq_data = 8'h03;            end
                3'd3:    begin w_seq_cmd = c_CMD_WRITE; w_seq_data = CFG_VALUE;        end
                default: w_seq_cmd = c_CMD_STOP;
            endcase
        end
        if (r_abort) begin
            w_seq_cmd  = c_CMD_STOP;
            w_seq_data = 8'h00;
        end
    end

    assign w_rsp        = (r_state == ST_RESP) && rsp_valid;
    assign w_retry_done = ({30'd0, r_retry} >= 32'(MAX_RETRY));

    always_ff @(posedge system_clk) begin
        if (Rst) begin
            r_state <= ST_LAUNCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_valid   = 1'b0;
        cmd         = 3'd0;
        cmd_data    = 8'h00;
        busy        = 1'b0;
        fault       = 1'b0;
        case (r_state)
            ST_LAUNCH: w_state_nxt = ST_OFFER;
            ST_OFFER: begin
                cmd_valid = 1'b1;
                cmd       = w_seq_cmd;
                cmd_data  = w_seq_data;
                busy      = 1'b1;
                if (cmd_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy = 1'b1;
                if (w_rsp) begin
                    if (w_seq_cmd != c_CMD_STOP) begin
                        w_state_nxt = ST_OFFER;
                    end else if (r_abort && !r_is_read) begin
                        w_state_nxt = w_retry_done ? ST_FAULT : ST_OFFER;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if ((r_poll == 27'd0) && enable) begin
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_FAULT: fault = 1'b1;
            default:  w_state_nxt = ST_LAUNCH;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (Rst) begin
            r_is_read    <= 1'b0;
            r_step       <= 3'd0;
            r_abort      <= 1'b0;
            r_retry      <= 2'd0;
            r_poll       <= 27'd0;
            r_msb        <= 8'h00;
            r_lsb        <= 8'h00;
            r_temp       <= 16'h0000;
            r_temp_valid <= 1'b0;
            r_err_cnt    <= 8'h00;
        end else begin
            r_temp_valid <= 1'b0;
            if (w_rsp) begin
                if (w_seq_cmd == c_CMD_STOP) begin
                    r_step  <= 3'd0;
                    r_abort <= 1'b0;
                    r_poll  <= c_POLL_LOAD;
                    if (!r_abort) begin
                        r_retry <= 2'd0;
                        if (r_is_read) begin
                            r_temp       <= {r_msb, r_lsb};
                            r_temp_valid <= 1'b1;
                        end
                    end
                    // A failed config attempt repeats config; everything else polls
                    if (r_is_read || !r_abort) begin
                        r_is_read <= 1'b1;
                    end
                end else if ((w_seq_cmd == c_CMD_WRITE) && rsp_nack) begin
                    r_abort <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (!r_is_read) begin
                        r_retry <= r_retry + 2'd1;
                    end
                end else begin
                    if (w_seq_cmd == c_CMD_RACK) begin
                        r_msb <= rsp_data;
                    end
                    if (w_seq_cmd == c_CMD_RNACK) begin
                        r_lsb <= rsp_data;
                    end
                    r_step <= r_step + 3'd1;
                end
            end else if ((r_state == ST_WAIT) && (r_poll != 27'd0)) begin
                r_poll <= r_poll - 27'd1;
            end
        end
    end

    assign temperature = r_temp;
    assign temp_valid  = r_temp_valid;
    assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire
